// File: rtl/store_checker_pkg.sv
// Shared types and default parameter values for the store checker.
package store_checker_pkg;

    localparam int unsigned DEF_XLEN           = 32;
    localparam int unsigned DEF_DEPTH          = 4;
    localparam int unsigned DEF_IGNORE_ADR     = 96;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;
    localparam int unsigned WCNT_W             = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

endpackage

// File: rtl/store_checker_table.sv
// Expected-store table: DEPTH entries of {address, data}.
// One synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a program survives a checker reset.
module store_checker_table #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_widx,
    input  logic [XLEN-1:0]          i_wadr,
    input  logic [XLEN-1:0]          i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_ridx,
    output logic [XLEN-1:0]          o_radr,
    output logic [XLEN-1:0]          o_rdata
);

    logic [2*XLEN-1:0] r_mem [DEPTH];

    // Write one entry per cycle when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= {i_wadr, i_wdata};
        end
    end

    assign {o_radr, o_rdata} = r_mem[i_ridx];

endmodule

// File: rtl/store_checker.sv
// Store checker: compares a core's store stream against a programmed
// sequence of expected {address, data} stores.
// Optional feature: define STORE_CHECKER_TIMEOUT_EN to enable the RUN-state
// cycle limit and the TIMEOUT state; otherwise RUN lasts until PASS/FAIL/reset.
module store_checker
    import store_checker_pkg::*;
#(
    parameter int unsigned XLEN           = DEF_XLEN,
    parameter int unsigned DEPTH          = DEF_DEPTH,
    parameter int unsigned IGNORE_ADR     = DEF_IGNORE_ADR,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [XLEN-1:0]          DataAdr,
    input  logic [XLEN-1:0]          WriteData,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_idx,
    input  logic [XLEN-1:0]          cfg_adr,
    input  logic [XLEN-1:0]          cfg_data,
    input  logic [$clog2(DEPTH):0]   cfg_len,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic                     timeout,
    output logic [15:0]              write_count,
    output logic [XLEN-1:0]          err_adr,
    output logic [XLEN-1:0]          err_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned LEN_W = IDX_W + 1;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
    logic [LEN_W-1:0]    r_len, w_len_nxt;
    logic [WCNT_W-1:0]   r_wcnt, w_wcnt_nxt;
    logic [XLEN-1:0]     r_err_adr, w_err_adr_nxt;
    logic [XLEN-1:0]     r_err_data, w_err_data_nxt;
    logic                r_busy, r_done, r_pass, r_fail;
    logic                w_tbl_we;
    logic [XLEN-1:0]     w_exp_adr, w_exp_data;
    logic                w_match, w_ignore, w_last;
    logic [WCNT_W-1:0]   w_wcnt_inc;

`ifdef STORE_CHECKER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_timeout;
`else
    logic                w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

    store_checker_table #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_table (
        .clk     (clk),
        .i_we    (w_tbl_we && !reset),
        .i_widx  (cfg_idx),
        .i_wadr  (cfg_adr),
        .i_wdata (cfg_data),
        .i_ridx  (r_ptr),
        .o_radr  (w_exp_adr),
        .o_rdata (w_exp_data)
    );

    // Store classification against the entry the pointer selects.
    assign w_ignore   = (DataAdr == XLEN'(IGNORE_ADR));
    assign w_match    = ({DataAdr, WriteData} == {w_exp_adr, w_exp_data});
    assign w_last     = ((LEN_W'(r_ptr) + LEN_W'(1)) == r_len);
    assign w_wcnt_inc = (r_wcnt == {WCNT_W{1'b1}}) ? r_wcnt : (r_wcnt + WCNT_W'(1));

    // Next-state and next-value logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_len_nxt      = r_len;
        w_wcnt_nxt     = r_wcnt;
        w_err_adr_nxt  = r_err_adr;
        w_err_data_nxt = r_err_data;
        w_tbl_we       = 1'b0;
`ifdef STORE_CHECKER_TIMEOUT_EN
        w_cnt_nxt      = r_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                w_tbl_we = cfg_we;
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_len_nxt   = cfg_len;
                    w_ptr_nxt   = '0;
                    w_wcnt_nxt  = '0;
`ifdef STORE_CHECKER_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            ST_RUN: begin
`ifdef STORE_CHECKER_TIMEOUT_EN
                w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
                if (r_len == '0) begin
                    w_state_nxt = ST_PASS;
                end else if (MemWrite) begin
                    w_wcnt_nxt = w_wcnt_inc;
                    if (w_ignore) begin
                        w_state_nxt = ST_RUN;
                    end else if (w_match) begin
                        w_ptr_nxt = r_ptr + IDX_W'(1);
                        if (w_last) begin
                            w_state_nxt = ST_PASS;
                        end
                    end else begin
                        w_err_adr_nxt  = DataAdr;
                        w_err_data_nxt = WriteData;
                        w_state_nxt    = ST_FAIL;
                    end
                end
`ifdef STORE_CHECKER_TIMEOUT_EN
                // A completing or failing store in the limit cycle takes priority.
                if ((w_state_nxt == ST_RUN) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    w_state_nxt = ST_TIMEOUT;
                end
`endif
            end
            default: begin
                // Terminal states hold until a new start; the table is kept.
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_len_nxt   = cfg_len;
                    w_ptr_nxt   = '0;
                    w_wcnt_nxt  = '0;
`ifdef STORE_CHECKER_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_len      <= '0;
            r_wcnt     <= '0;
            r_err_adr  <= '0;
            r_err_data <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_len      <= w_len_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_err_adr  <= w_err_adr_nxt;
            r_err_data <= w_err_data_nxt;
            r_busy     <= (w_state_nxt == ST_RUN);
            r_done     <= (w_state_nxt == ST_PASS) || (w_state_nxt == ST_FAIL)
                          || (w_state_nxt == ST_TIMEOUT);
            r_pass     <= (w_state_nxt == ST_PASS);
            r_fail     <= (w_state_nxt == ST_FAIL);
        end
    end

`ifdef STORE_CHECKER_TIMEOUT_EN
    // RUN cycle counter and timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_timeout <= (w_state_nxt == ST_TIMEOUT);
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign write_count = r_wcnt;
    assign err_adr     = r_err_adr;
    assign err_data    = r_err_data;

endmodule

// File: tb/tb_store_checker.sv
// Self-checking bench for store_checker: directed scenarios with literal
// expectations plus randomized store streams against a behavioural model.
module tb_store_checker;

    localparam int XLEN = 32;
    localparam int IGN  = 96;
    localparam int TO   = 16;
`ifdef STORE_CHECKER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // Model phase codes.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PASS = 2;
    localparam int M_FAIL = 3;
    localparam int M_TO   = 4;

    logic            clk = 1'b0;
    logic            reset, MemWrite, cfg_we, start;
    logic [XLEN-1:0] DataAdr, WriteData, cfg_adr, cfg_data;
    logic [1:0]      cfg_idx;
    logic [2:0]      cfg_len;
    logic            busy, done, pass, fail, timeout;
    logic [15:0]     write_count;
    logic [XLEN-1:0] err_adr, err_data;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model state.
    int              m_st, m_len, m_matched, m_elapsed, m_wc;
    logic [XLEN-1:0] m_ea, m_ed;
    logic [XLEN-1:0] m_ta [4];
    logic [XLEN-1:0] m_td [4];

    store_checker #(
        .XLEN           (XLEN),
        .DEPTH          (4),
        .IGNORE_ADR     (IGN),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_adr     (cfg_adr),
        .cfg_data    (cfg_data),
        .cfg_len     (cfg_len),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .write_count (write_count),
        .err_adr     (err_adr),
        .err_data    (err_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic launch();
        m_st      = M_RUN;
        m_len     = int'(cfg_len);
        m_matched = 0;
        m_elapsed = 0;
        m_wc      = 0;
    endtask

    // One clock of the checker's rules, applied to the inputs seen at the edge.
    task automatic model_step();
        if (reset) begin
            m_st = M_IDLE; m_len = 0; m_matched = 0; m_elapsed = 0; m_wc = 0;
            m_ea = '0; m_ed = '0;
            return;
        end
        if (m_st == M_IDLE) begin
            if (cfg_we) begin
                m_ta[cfg_idx] = cfg_adr;
                m_td[cfg_idx] = cfg_data;
            end
            if (start) launch();
        end else if (m_st == M_RUN) begin
            if (m_len == 0) begin
                m_st = M_PASS;
            end else if (MemWrite) begin
                m_wc = (m_wc == 65535) ? 65535 : m_wc + 1;
                if (DataAdr == IGN) begin
                    // scratch store: counted only
                end else if (DataAdr == m_ta[m_matched] && WriteData == m_td[m_matched]) begin
                    m_matched++;
                    if (m_matched == m_len) m_st = M_PASS;
                end else begin
                    m_ea = DataAdr;
                    m_ed = WriteData;
                    m_st = M_FAIL;
                end
            end
            if (TO_EN && m_st == M_RUN && m_elapsed == TO - 1) m_st = M_TO;
            m_elapsed++;
        end else begin
            if (start) launch();
        end
    endtask

    // Advance the model at each edge, then compare all outputs just after it.
    always @(posedge clk) begin
        model_step();
        #1;
        if (chk_en) begin
            chk("busy",        32'(busy),        32'(m_st == M_RUN));
            chk("done",        32'(done),        32'(m_st >= M_PASS));
            chk("pass",        32'(pass),        32'(m_st == M_PASS));
            chk("fail",        32'(fail),        32'(m_st == M_FAIL));
            chk("timeout",     32'(timeout),     32'(m_st == M_TO));
            chk("write_count", 32'(write_count), 32'(m_wc));
            chk("err_adr",     err_adr,          m_ea);
            chk("err_data",    err_data,         m_ed);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg(input int idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_adr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic go(input int len);
        cfg_len = 3'(len); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; DataAdr = a; WriteData = d;
        tick();
        MemWrite = 1'b0; DataAdr = 'x; WriteData = 'x;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_adr();
        if ($urandom_range(0, 9) == 0) return 32'(IGN);
        return 32'(100 + 4 * $urandom_range(0, 3));
    endfunction

    initial begin
        reset = 1'b1; MemWrite = 1'b0; DataAdr = 'x; WriteData = 'x;
        cfg_we = 1'b0; cfg_idx = '0; cfg_adr = '0; cfg_data = '0;
        cfg_len = '0; start = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wcnt", 32'(write_count), 0);
        reset = 1'b0;

        // Single expected store with a scratch store first.
        cfg(0, 100, 25);
        go(1);
        st(96, 7);
        st(100, 25);
        chk("t1_pass", 32'(pass), 1);
        chk("t1_done", 32'(done), 1);
        chk("t1_wcnt", 32'(write_count), 2);
        chk("t1_fail", 32'(fail), 0);

        // Wrong data: fail captured, later correct store does not rescue it.
        go(1);
        st(100, 24);
        chk("t2_fail", 32'(fail), 1);
        chk("t2_eadr", err_adr, 100);
        chk("t2_edat", err_data, 24);
        st(100, 25);
        chk("t2_pass", 32'(pass), 0);
        chk("t2_wcnt", 32'(write_count), 1);

        // Table write outside IDLE is ignored; reset keeps the table.
        cfg(0, 200, 1);
        pulse_reset();
        cfg(1, 104, 3);
        cfg(2, 108, 9);
        MemWrite = 1'b1; DataAdr = 100; WriteData = 25;
        go(3);
        MemWrite = 1'b0; DataAdr = 'x; WriteData = 'x;
        chk("t3_wcnt0", 32'(write_count), 0);
        st(100, 25);
        st(96, 1);
        st(104, 3);
        st(96, 2);
        chk("t3_busy", 32'(busy), 1);
        chk("t3_pass0", 32'(pass), 0);
        st(108, 9);
        chk("t3_pass", 32'(pass), 1);
        chk("t3_wcnt", 32'(write_count), 5);

        // Out-of-order store fails immediately.
        go(3);
        st(104, 3);
        chk("t4_fail", 32'(fail), 1);
        chk("t4_eadr", err_adr, 104);

        // Timeout exactly TO cycles after RUN entry, or RUN persists.
        go(3);
        if (TO_EN) begin
            repeat (TO - 1) tick();
            chk("t5_to_early", 32'(timeout), 0);
            tick();
            chk("t5_to", 32'(timeout), 1);
            chk("t5_busy", 32'(busy), 0);
        end else begin
            repeat (100) tick();
            chk("t5_busy100", 32'(busy), 1);
            chk("t5_to0", 32'(timeout), 0);
        end
        pulse_reset();

        // Zero-length sequence passes two cycles after start.
        go(0);
        chk("t6_busy", 32'(busy), 1);
        tick();
        chk("t6_pass", 32'(pass), 1);

        // Reset mid-RUN clears outputs; table survives for a restart.
        go(2);
        st(100, 25);
        chk("t7_wcnt1", 32'(write_count), 1);
        pulse_reset();
        chk("t7_busy", 32'(busy), 0);
        chk("t7_done", 32'(done), 0);
        chk("t7_wcnt", 32'(write_count), 0);
        chk("t7_eadr", err_adr, 0);
        go(1);
        st(100, 25);
        chk("t7_pass", 32'(pass), 1);

        // Randomized sequences.
        pulse_reset();
        for (int k = 0; k < 4; k++) cfg(k, 32'(100 + 4 * k), 32'(k));
        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(0, 2) == 0) pulse_reset();
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 1) == 1) cfg(k, rand_adr(), 32'($urandom_range(0, 3)));
            go(int'($urandom_range(1, 4)));
            for (int c = 0; c < 24; c++) begin
                int p;
                p = int'($urandom_range(0, 9));
                if (p < 4 && m_st == M_RUN && m_matched < 4) begin
                    st(m_ta[m_matched], m_td[m_matched]);
                end else if (p < 6) begin
                    st(32'(IGN), $urandom);
                end else if (p < 7) begin
                    st(rand_adr(), 32'($urandom_range(0, 3)));
                end else if (p < 8) begin
                    cfg(int'($urandom_range(0, 3)), rand_adr(), 32'($urandom_range(0, 3)));
                end else begin
                    DataAdr = $urandom; WriteData = 'x;
                    tick();
                    DataAdr = 'x;
                end
            end
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
